// File: rtl/syscall_ctrl.sv
// Sequencer for the MIPS syscall instruction: it stalls decode, reads $v0 and $a0
// through register-file port A, runs the halt, display or no-op service, then retires the syscall.
module syscall_ctrl #(
    parameter int unsigned PAUSE_CYCLES = 4,
    parameter logic [31:0] HALT_CODE    = 32'd10,
    parameter logic [31:0] SHOW_CODE    = 32'd34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OP,
    input  logic [5:0]  FUNC,
    input  logic        istr_valid,
    input  logic        go,
    input  logic [31:0] rf_rd_data,
    output logic [4:0]  rf_raddr,
    output logic        port_sel,
    output logic        stall,
    output logic        halted,
    output logic [31:0] disp_data,
    output logic        disp_we,
    output logic [15:0] syscall_cnt
);

    localparam logic [5:0]  FUNC_SYSCALL = 6'b001100;
    localparam logic [4:0]  REG_V0       = 5'd2;
    localparam logic [4:0]  REG_A0       = 5'd4;
    localparam logic [15:0] PAUSE_LOAD   = 16'(PAUSE_CYCLES - 1);

    if (PAUSE_CYCLES < 1 || PAUSE_CYCLES > 65535) begin : g_bad_pause
        $error("syscall_ctrl: PAUSE_CYCLES must lie in 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_V0 = 3'd1,
        RD_A0 = 3'd2,
        SHOW  = 3'd3,
        HALT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] v0_q, v0_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic        disp_we_q, disp_we_d;
    logic [15:0] syscall_cnt_q, syscall_cnt_d;

    logic        hit;
    logic        stall_c;
    logic        halted_c;
    logic        port_sel_c;
    logic [4:0]  rf_raddr_c;

    assign hit = istr_valid && (OP == 6'd0) && (FUNC == FUNC_SYSCALL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            v0_q          <= '0;
            cnt_q         <= '0;
            disp_data_q   <= '0;
            disp_we_q     <= 1'b0;
            syscall_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            v0_q          <= v0_d;
            cnt_q         <= cnt_d;
            disp_data_q   <= disp_data_d;
            disp_we_q     <= disp_we_d;
            syscall_cnt_q <= syscall_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        v0_d          = v0_q;
        cnt_d         = cnt_q;
        disp_data_d   = disp_data_q;
        disp_we_d     = 1'b0;
        syscall_cnt_d = syscall_cnt_q;
        stall_c       = 1'b0;
        halted_c      = 1'b0;
        port_sel_c    = 1'b0;
        rf_raddr_c    = 5'd0;

        case (state_q)
            IDLE: begin
                stall_c = hit;
                if (hit) begin
                    state_d = RD_V0;
                end
            end
            RD_V0: begin
                stall_c    = 1'b1;
                port_sel_c = 1'b1;
                rf_raddr_c = REG_V0;
                v0_d       = rf_rd_data;
                state_d    = RD_A0;
            end
            RD_A0: begin
                stall_c    = 1'b1;
                port_sel_c = 1'b1;
                rf_raddr_c = REG_A0;
                // Halt is checked first so it wins if both codes are configured equal.
                if (v0_q == HALT_CODE) begin
                    state_d = HALT;
                end else if (v0_q == SHOW_CODE) begin
                    disp_data_d = rf_rd_data;
                    disp_we_d   = 1'b1;
                    cnt_d       = PAUSE_LOAD;
                    state_d     = SHOW;
                end else begin
                    state_d = DONE;
                end
            end
            SHOW: begin
                stall_c = 1'b1;
                if (cnt_q == 16'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HALT: begin
                stall_c  = 1'b1;
                halted_c = 1'b1;
                if (go) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The syscall still sitting in decode retires here, so hit must not re-trigger.
                syscall_cnt_d = syscall_cnt_q + 16'd1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IDLE stall follows decode combinationally; hold it low while reset is asserted.
    assign stall       = stall_c && !rst;
    assign halted      = halted_c;
    assign port_sel    = port_sel_c;
    assign rf_raddr    = rf_raddr_c;
    assign disp_data   = disp_data_q;
    assign disp_we     = disp_we_q;
    assign syscall_cnt = syscall_cnt_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl: no-op, display, halt, back-to-back,
// reset during display and counter wrap, with a behavioural register file.
module tb_syscall_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  OP;
    logic [5:0]  FUNC;
    logic        istr_valid;
    logic        go;
    logic [31:0] rf_rd_data;
    logic [4:0]  rf_raddr;
    logic        port_sel;
    logic        stall;
    logic        halted;
    logic [31:0] disp_data;
    logic        disp_we;
    logic [15:0] syscall_cnt;

    logic [31:0] v0_val;
    logic [31:0] a0_val;

    int n_checks;
    int n_errors;

    syscall_ctrl #(
        .PAUSE_CYCLES(4),
        .HALT_CODE   (32'd10),
        .SHOW_CODE   (32'd34)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .OP         (OP),
        .FUNC       (FUNC),
        .istr_valid (istr_valid),
        .go         (go),
        .rf_rd_data (rf_rd_data),
        .rf_raddr   (rf_raddr),
        .port_sel   (port_sel),
        .stall      (stall),
        .halted     (halted),
        .disp_data  (disp_data),
        .disp_we    (disp_we),
        .syscall_cnt(syscall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rf_rd_data = 32'h5A5A_5A5A;
        if (port_sel) begin
            if (rf_raddr == 5'd2)      rf_rd_data = v0_val;
            else if (rf_raddr == 5'd4) rf_rd_data = a0_val;
            else                       rf_rd_data = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        OP         = 6'd0;
        FUNC       = 6'b001100;
        istr_valid = 1'b1;
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        OP         = 6'd0;
        FUNC       = 6'd0;
        istr_valid = 1'b0;
        go         = 1'b0;
        v0_val     = 32'd0;
        a0_val     = 32'd0;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_halted", halted, 0);
        chk("rst_port_sel", port_sel, 0);
        chk("rst_raddr", rf_raddr, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_disp_we", disp_we, 0);
        chk("rst_cnt", syscall_cnt, 0);
        step();
        step();
        rst = 1'b0;

        // Near-miss opcodes must not be detected
        OP = 6'd1; FUNC = 6'b001100; istr_valid = 1'b1; #1;
        chk("nohit_op", stall, 0);
        OP = 6'd0; FUNC = 6'b001101; #1;
        chk("nohit_func", stall, 0);
        FUNC = 6'b001100; istr_valid = 1'b0; #1;
        chk("nohit_valid", stall, 0);
        step();

        // Non-service syscall
        v0_val = 32'd5; a0_val = 32'd7;
        issue();
        chk("ns_c0_stall", stall, 1);
        chk("ns_c0_psel", port_sel, 0);
        step();
        chk("ns_c1_stall", stall, 1);
        chk("ns_c1_psel", port_sel, 1);
        chk("ns_c1_raddr", rf_raddr, 2);
        chk("ns_c1_we", disp_we, 0);
        step();
        chk("ns_c2_stall", stall, 1);
        chk("ns_c2_raddr", rf_raddr, 4);
        chk("ns_c2_we", disp_we, 0);
        step();
        chk("ns_c3_stall", stall, 0);
        chk("ns_c3_psel", port_sel, 0);
        chk("ns_c3_we", disp_we, 0);
        chk("ns_c3_cnt", syscall_cnt, 0);
        step();
        istr_valid = 1'b0; #1;
        chk("ns_c4_cnt", syscall_cnt, 1);
        chk("ns_c4_stall", stall, 0);
        chk("ns_c4_disp", disp_data, 0);

        // Display service, PAUSE_CYCLES = 4
        step();
        v0_val = 32'd34; a0_val = 32'hDEAD_BEEF;
        issue();
        chk("sh_c0_stall", stall, 1);
        step();
        chk("sh_c1_raddr", rf_raddr, 2);
        step();
        chk("sh_c2_raddr", rf_raddr, 4);
        chk("sh_c2_we", disp_we, 0);
        step();
        chk("sh_c3_we", disp_we, 1);
        chk("sh_c3_data", disp_data, 32'hDEAD_BEEF);
        chk("sh_c3_stall", stall, 1);
        chk("sh_c3_psel", port_sel, 0);
        for (int i = 4; i <= 6; i++) begin
            step();
            chk($sformatf("sh_c%0d_stall", i), stall, 1);
            chk($sformatf("sh_c%0d_we", i), disp_we, 0);
        end
        step();
        chk("sh_c7_stall", stall, 0);
        chk("sh_c7_data", disp_data, 32'hDEAD_BEEF);
        step();
        istr_valid = 1'b0; #1;
        chk("sh_c8_cnt", syscall_cnt, 2);

        // Halt service; go pulsed early must be ignored
        step();
        v0_val = 32'd10; a0_val = 32'd0;
        issue();
        step();
        go = 1'b1;
        step();
        step();
        go = 1'b0; #1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("ht_hold%0d_halted", i), halted, 1);
            chk($sformatf("ht_hold%0d_stall", i), stall, 1);
            step();
        end
        go = 1'b1; #1;
        chk("ht_go_halted", halted, 1);
        step();
        go = 1'b0; #1;
        chk("ht_done_halted", halted, 0);
        chk("ht_done_stall", stall, 0);
        chk("ht_done_cnt", syscall_cnt, 2);
        step();
        istr_valid = 1'b0; #1;
        chk("ht_after_cnt", syscall_cnt, 3);

        // Back-to-back syscalls with $v0 = 1
        step();
        v0_val = 32'd1;
        issue();
        step();
        step();
        step();
        chk("bb_done1_stall", stall, 0);
        step();
        chk("bb_idle_stall", stall, 1);
        chk("bb_idle_psel", port_sel, 0);
        chk("bb_idle_cnt", syscall_cnt, 4);
        step();
        chk("bb_rdv0_raddr", rf_raddr, 2);
        step();
        chk("bb_rda0_raddr", rf_raddr, 4);
        step();
        chk("bb_done2_stall", stall, 0);
        step();
        istr_valid = 1'b0; #1;
        chk("bb_final_cnt", syscall_cnt, 5);
        chk("bb_final_stall", stall, 0);

        // Reset while in SHOW with cnt == 2, then a normal syscall
        step();
        v0_val = 32'd34; a0_val = 32'h1234_5678;
        issue();
        step(); step(); step();
        chk("rs_show_we", disp_we, 1);
        step();
        #1;
        rst = 1'b1; #1;
        chk("rs_stall", stall, 0);
        chk("rs_halted", halted, 0);
        chk("rs_psel", port_sel, 0);
        chk("rs_raddr", rf_raddr, 0);
        chk("rs_disp", disp_data, 0);
        chk("rs_we", disp_we, 0);
        chk("rs_cnt", syscall_cnt, 0);
        rst = 1'b0;
        v0_val = 32'd5; #1;
        chk("rs_rehit_stall", stall, 1);
        step();
        chk("rs_rdv0_raddr", rf_raddr, 2);
        step();
        chk("rs_rda0_raddr", rf_raddr, 4);
        step();
        chk("rs_done_stall", stall, 0);
        step();
        istr_valid = 1'b0; #1;
        chk("rs_after_cnt", syscall_cnt, 1);

        // Counter wrap from 0xFFFF
        force dut.syscall_cnt_q = 16'hFFFF;
        #1;
        release dut.syscall_cnt_q;
        #1;
        chk("wr_preload", syscall_cnt, 16'hFFFF);
        step();
        v0_val = 32'd7;
        issue();
        step(); step(); step();
        chk("wr_done_cnt", syscall_cnt, 16'hFFFF);
        step();
        istr_valid = 1'b0; #1;
        chk("wr_wrapped", syscall_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/syscall_ctrl.md
# syscall_ctrl

Multi-cycle sequencer for the MIPS `syscall` instruction (OP=000000, FUNC=001100) in the FPGA CPU. It sits beside the instruction field splitter and the register file. On a syscall in decode it stalls the pipeline and takes over register-file read port A to fetch $v0 (r2) and $a0 (r4). It then performs the service: halt until `go`, show $a0 on the display latch for a fixed hold time, or no-op. Finally it releases the instruction for exactly one cycle.

## Interface
Parameters:
- PAUSE_CYCLES, 4, cycles spent in SHOW; legal range 1..65535
- HALT_CODE, 10, $v0 value selecting halt service
- SHOW_CODE, 34, $v0 value selecting display service

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- OP  in  6  opcode of instruction in decode
- FUNC  in  6  function field of instruction in decode
- istr_valid  in  1  decode holds a valid instruction
- go  in  1  resume request, level-sampled, honoured only in HALT
- rf_rd_data  in  32  combinational read data of register-file port A
- rf_raddr  out  5  port-A address when port_sel=1, else 0
- port_sel  out  1  1 = controller owns port A (decode address muxed out)
- stall  out  1  freeze PC and decode register
- halted  out  1  CPU halted by syscall
- disp_data  out  32  display latch
- disp_we  out  1  one-cycle pulse when disp_data is updated
- syscall_cnt  out  16  count of retired syscalls

## Operation
- States: IDLE, RD_V0, RD_A0, SHOW, HALT, DONE. Reset state is IDLE.
- Internal registers: v0_q (32), cnt (16).
- Detection: `hit = istr_valid && OP==0 && FUNC==6'b001100`.
- IDLE
  - stall = hit (combinational). port_sel=0.
  - hit → RD_V0.
- RD_V0
  - port_sel=1, rf_raddr=2, stall=1.
  - v0_q ← rf_rd_data.
  - → RD_A0.
- RD_A0
  - port_sel=1, rf_raddr=4, stall=1.
  - If v0_q==HALT_CODE → HALT.
  - Else if v0_q==SHOW_CODE: disp_data ← rf_rd_data, disp_we ← 1, cnt ← PAUSE_CYCLES−1, → SHOW.
  - Else → DONE.
- SHOW
  - stall=1, port_sel=0. disp_we is high only in the first SHOW cycle.
  - cnt==0 → DONE; else cnt ← cnt−1.
- HALT
  - stall=1, halted=1.
  - go=1 → DONE; otherwise stay.
- DONE
  - stall=0 for this one cycle; the syscall leaves decode on this edge. syscall_cnt ← syscall_cnt+1 (wraps mod 2^16).
  - → IDLE. hit is ignored in DONE, because the instruction still visible is the one retiring.
- `go` outside HALT has no effect. HALT_CODE takes priority if it equals SHOW_CODE.
- Outputs not listed for a state are 0, except the registered outputs disp_data and syscall_cnt, which hold their value.

## Timing
- Reset (asynchronous, any state): state=IDLE, v0_q=0, cnt=0, disp_data=0, disp_we=0, syscall_cnt=0, stall=0, halted=0, port_sel=0, rf_raddr=0.
- A syscall in decode at cycle 0 gives the following states and stall pattern:
  - Other code: IDLE(0), RD_V0(1), RD_A0(2), DONE(3). stall high in cycles 0–2, low in cycle 3; the next instruction enters decode at cycle 4.
  - SHOW: RD_A0(2), SHOW(3..2+PAUSE_CYCLES), DONE(3+PAUSE_CYCLES). disp_we high in cycle 3.
  - HALT: HALT from cycle 3. If go is sampled high at edge k, DONE is in cycle k+1.
- rf_rd_data is sampled at the end of the RD_V0 and RD_A0 cycles. The register file read is combinational within one cycle.
- Back-to-back syscalls: the second one is detected in IDLE in the cycle after DONE. No cycles are lost beyond the fixed sequence.
- Reset asserted mid-sequence abandons the service. The display is cleared and the counter is not incremented.

## Test plan
- Non-service syscall: $v0=5, $a0=7 → stall high for 3 cycles, one DONE cycle, syscall_cnt 0→1, disp_we never high, rf_raddr sequence 2 then 4.
- Display service: $v0=34, $a0=0xDEADBEEF, PAUSE_CYCLES=4 → disp_data=0xDEADBEEF with one disp_we pulse in cycle 3, stall high for cycles 0–6, DONE in cycle 7.
- Halt service: $v0=10 → halted=1 and stall=1 held for 20 cycles; go ignored before HALT; go pulse → halted=0 next cycle, DONE, syscall_cnt increments.
- Back-to-back: two consecutive syscalls with $v0=1 → two full sequences separated by exactly one IDLE detection; syscall_cnt=2; no double count in DONE.
- Asynchronous reset during SHOW, with cnt=2 → all outputs immediately 0, state IDLE; syscall_cnt unchanged from 0; a new syscall afterwards runs normally.
- Counter wrap: preload via 65536 non-service syscalls (or force) → syscall_cnt 0xFFFF→0x0000.
